series_adder_ctrl: RTL

//  Sequencer for series_adder. Takes one batch of M parallel N-bit operands through a valid/ready handshake.

---
 rtl/series_adder_pkg.sv | 24 ++
 rtl/series_adder_shreg.sv | 47 ++++
 rtl/series_adder_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/series_adder_pkg.sv
// series_adder_pkg: shared FSM type and width/lane helpers for the series-adder sequencer.
package series_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   function automatic int res_w(input int m, input int n);
      return $clog2(m) + n;
   endfunction

   // Word k drives add_data bit (m-1-k), so word 0 lands on the MSB.
   function automatic int lane_pos(input int m, input int k);
      return m - 1 - k;
   endfunction

   function automatic int cnt_w(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/series_adder_shreg.sv
// series_adder_shreg: M parallel-load, LSB-first shift lanes. o_bits is registered and
// presents bit 0 of every word in the cycle right after the load.
module series_adder_shreg
   import series_adder_pkg::*;
#(
   parameter int M = 8,
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst_p,
   input  logic           i_load,
   input  logic           i_shift,
   input  logic           i_clear,
   input  logic [M*N-1:0] i_words,
   output logic [M-1:0]   o_bits
);

   logic [N-1:0] r_word [M];
   logic [M-1:0] r_bits;

   // Lane storage: load keeps bits 1..N-1 while bit 0 goes straight to the output slice.
   always_ff @(posedge clk) begin
      if (rst_p) begin
         r_bits <= '0;
         for (int k = 0; k < M; k++) begin
            r_word[k] <= '0;
         end
      end else if (i_clear) begin
         r_bits <= '0;
      end else if (i_load) begin
         for (int k = 0; k < M; k++) begin
            r_bits[k] <= i_words[k*N];
            r_word[k] <= {1'b0, i_words[k*N+1 +: N-1]};
         end
      end else if (i_shift) begin
         for (int k = 0; k < M; k++) begin
            r_bits[k] <= r_word[k][0];
            r_word[k] <= {1'b0, r_word[k][N-1:1]};
         end
      end else begin
         r_bits <= r_bits;
      end
   end

   assign o_bits = r_bits;

endmodule

// File: rtl/series_adder_ctrl.sv
// series_adder_ctrl: accepts an M x N operand batch, streams it bit-serially into
// series_adder, waits (with a watchdog) for the sum and hands it out via valid/ready.
module series_adder_ctrl
   import series_adder_pkg::*;
#(
   parameter int M       = 8,
   parameter int N       = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst_p,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [M*N-1:0]        in_words,
   output logic [M-1:0]          add_data,
   output logic                  add_data_vld,
   input  logic                  add_result_vld,
   input  logic [res_w(M,N)-1:0] add_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [res_w(M,N)-1:0] out_result,
   output logic                  busy,
   output logic                  err_timeout
);

   localparam int RW = res_w(M, N);
   localparam int BW = cnt_w(N);
   localparam int TW = cnt_w(TIMEOUT);
   localparam logic [BW-1:0] LAST_BIT  = BW'(N - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

   state_t          r_state, w_state_nxt;
   logic [BW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
   logic [TW-1:0]   r_wd_cnt, w_wd_cnt_nxt;
   logic [RW-1:0]   r_out_result, w_out_result_nxt;
   logic            r_in_ready, r_add_data_vld, r_out_valid, r_busy, r_err_timeout;
   logic            w_add_data_vld_nxt, w_err_timeout_nxt;
   logic            w_accept, w_last_bit, w_wd_expired;
   logic            w_load, w_shift, w_clear;
   logic [M-1:0]    w_bits;

   assign w_accept     = in_valid && r_in_ready;
   assign w_last_bit   = (r_bit_cnt == LAST_BIT);
   assign w_wd_expired = (r_wd_cnt == LAST_TICK);

   series_adder_shreg #(.M(M), .N(N)) u_shreg (
      .clk     (clk),
      .rst_p   (rst_p),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_clear (w_clear),
      .i_words (in_words),
      .o_bits  (w_bits)
   );

   for (genvar k = 0; k < M; k++) begin : g_lane
      assign add_data[lane_pos(M, k)] = w_bits[k];
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst_p) begin
         r_state        <= IDLE;
         r_bit_cnt      <= '0;
         r_wd_cnt       <= '0;
         r_out_result   <= '0;
         r_in_ready     <= 1'b1;
         r_add_data_vld <= 1'b0;
         r_out_valid    <= 1'b0;
         r_busy         <= 1'b0;
         r_err_timeout  <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_bit_cnt      <= w_bit_cnt_nxt;
         r_wd_cnt       <= w_wd_cnt_nxt;
         r_out_result   <= w_out_result_nxt;
         r_in_ready     <= (w_state_nxt == IDLE);
         r_add_data_vld <= w_add_data_vld_nxt;
         r_out_valid    <= (w_state_nxt == HOLD);
         r_busy         <= (w_state_nxt != IDLE);
         r_err_timeout  <= w_err_timeout_nxt;
      end
   end

   // Next-state decode; a result arriving on the final watchdog tick still wins.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = SHIFT; else w_state_nxt = IDLE;
         SHIFT:   if (w_last_bit) w_state_nxt = WAIT; else w_state_nxt = SHIFT;
         WAIT: begin
            if (add_result_vld)    w_state_nxt = HOLD;
            else if (w_wd_expired) w_state_nxt = IDLE;
            else                   w_state_nxt = WAIT;
         end
         HOLD:    if (out_ready) w_state_nxt = IDLE; else w_state_nxt = HOLD;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath controls and next values of the registered outputs.
   always_comb begin
      w_bit_cnt_nxt      = r_bit_cnt;
      w_wd_cnt_nxt       = r_wd_cnt;
      w_out_result_nxt   = r_out_result;
      w_add_data_vld_nxt = 1'b0;
      w_err_timeout_nxt  = 1'b0;
      w_load             = 1'b0;
      w_shift            = 1'b0;
      w_clear            = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_load             = 1'b1;
               w_bit_cnt_nxt      = '0;
               w_add_data_vld_nxt = 1'b1;
            end else begin
               w_load = 1'b0;
            end
         end
         SHIFT: begin
            if (w_last_bit) begin
               w_clear      = 1'b1;
               w_wd_cnt_nxt = '0;
            end else begin
               w_shift            = 1'b1;
               w_bit_cnt_nxt      = r_bit_cnt + BW'(1);
               w_add_data_vld_nxt = 1'b1;
            end
         end
         WAIT: begin
            if (add_result_vld) begin
               w_out_result_nxt = add_result;
            end else if (w_wd_expired) begin
               w_err_timeout_nxt = 1'b1;
            end else begin
               w_wd_cnt_nxt = r_wd_cnt + TW'(1);
            end
         end
         HOLD:    w_out_result_nxt = r_out_result;
         default: w_out_result_nxt = r_out_result;
      endcase
   end

   assign in_ready     = r_in_ready;
   assign add_data_vld = r_add_data_vld;
   assign out_valid    = r_out_valid;
   assign out_result   = r_out_result;
   assign busy         = r_busy;
   assign err_timeout  = r_err_timeout;

endmodule
